// File: rtl/float8_encoder_pkg.sv
`default_nettype none
// ============================================================================
// float8_encoder_pkg : Float8 field layout, exponent limits and encoder types
// Revision: 1.0
// ============================================================================
package float8_encoder_pkg;

  localparam int unsigned FIXED_W     = 16;
  localparam int unsigned F8_W        = 8;
  localparam int unsigned F8_SIGN_BIT = 7;
  localparam int unsigned F8_EXP_MSB  = 6;
  localparam int unsigned F8_EXP_LSB  = 3;
  localparam int unsigned F8_MANT_MSB = 2;
  localparam int unsigned F8_MANT_LSB = 0;
  localparam int unsigned F8_EXP_W    = 4;
  localparam int unsigned F8_MANT_W   = 3;

  // value = 1.mmm x 2^(E - EXP_BIAS); any word with [6:0] == 0 reads as zero
  localparam logic [F8_EXP_W-1:0] EXP_MAX  = 4'd15;
  localparam int unsigned         EXP_BIAS = 8;
  localparam logic [F8_W-1:0]     F8_ZERO  = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_NORM = 2'd1,
    ST_DONE = 2'd2
  } enc_state_e;

  typedef struct packed {
    logic                 sign;
    logic [F8_EXP_W-1:0]  exp;
    logic [F8_MANT_W-1:0] mant;
  } float8_t;

  // Two's-complement magnitude; 0x8000 maps onto itself as unsigned 32768.
  function automatic logic [FIXED_W-1:0] fixed_abs(input logic [FIXED_W-1:0] v);
    return v[FIXED_W-1] ? (~v + 16'd1) : v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/float8_encoder_if.sv
`default_nettype none
// ============================================================================
// float8_encoder_if : valid/ready operand and result channels of the encoder
// Revision: 1.0
// ============================================================================
interface float8_encoder_if;

  logic        iValid;
  logic        oReady;
  logic [15:0] iFixed;
  logic        oValid;
  logic        iReady;
  logic [7:0]  oNum;
  logic        oInexact;

  modport master (
    output iValid, iFixed, iReady,
    input  oReady, oValid, oNum, oInexact
  );

  modport slave (
    input  iValid, iFixed, iReady,
    output oReady, oValid, oNum, oInexact
  );

endinterface
`default_nettype wire

// File: rtl/float8_pack.sv
`default_nettype none
// ============================================================================
// float8_pack : assembles {sign, exp, mant} from a normalised magnitude
// Revision: 1.0
// ============================================================================
module float8_pack
  import float8_encoder_pkg::*;
(
  input  logic                 i_sign,
  input  logic [F8_EXP_W-1:0]  i_exp,
  input  logic [14:0]          i_frac,
  output logic [F8_W-1:0]      o_num,
  output logic                 o_inexact
);

  float8_t w_word;
  logic    w_flush;

  always_comb begin
    w_word.sign = i_sign;
    w_word.exp  = i_exp;
    w_word.mant = i_frac[14:12];
    // Leading one at bit 0 yields exp 0 / mant 0, which would alias zero.
    w_flush     = ({w_word.exp, w_word.mant} == 7'd0);
    if (w_flush) begin
      o_num     = F8_ZERO;
      o_inexact = 1'b1;
    end else begin
      o_num     = w_word;
      o_inexact = |i_frac[11:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/float8_encoder.sv
`default_nettype none
// ============================================================================
// float8_encoder : Q8.8 signed fixed point to Float8, one bit of normalise/cycle
// Revision: 1.0
// ============================================================================
module float8_encoder
  import float8_encoder_pkg::*;
(
  input  logic             iClk,
  input  logic             iRst_n,
  float8_encoder_if.slave  bus
);

  enc_state_e           state_q,   state_d;
  logic                 sign_q,    sign_d;
  logic [FIXED_W-1:0]   mag_q,     mag_d;
  logic [F8_EXP_W-1:0]  exp_q,     exp_d;
  logic                 valid_q,   valid_d;
  logic                 ready_q,   ready_d;
  logic [F8_W-1:0]      num_q,     num_d;
  logic                 inexact_q, inexact_d;

  logic [FIXED_W-1:0]   w_abs;
  logic                 w_accept;
  logic [F8_W-1:0]      w_pack_num;
  logic                 w_pack_inexact;

  assign w_abs    = fixed_abs(bus.iFixed);
  assign w_accept = bus.iValid && ready_q;

  float8_pack u_pack (
    .i_sign    (sign_q),
    .i_exp     (exp_q),
    .i_frac    (mag_q[14:0]),
    .o_num     (w_pack_num),
    .o_inexact (w_pack_inexact)
  );

  always_comb begin
    state_d   = state_q;
    sign_d    = sign_q;
    mag_d     = mag_q;
    exp_d     = exp_q;
    valid_d   = valid_q;
    ready_d   = ready_q;
    num_d     = num_q;
    inexact_d = inexact_q;
    case (state_q)
      ST_IDLE: begin
        if (w_accept) begin
          sign_d  = bus.iFixed[FIXED_W-1];
          mag_d   = w_abs;
          exp_d   = EXP_MAX;
          ready_d = 1'b0;
          if (w_abs == '0) begin
            sign_d    = 1'b0;
            num_d     = F8_ZERO;
            inexact_d = 1'b0;
            valid_d   = 1'b1;
            state_d   = ST_DONE;
          end else begin
            state_d = ST_NORM;
          end
        end
      end
      ST_NORM: begin
        // mag is nonzero here, so the leading one arrives before exp underflows
        if (mag_q[FIXED_W-1]) begin
          num_d     = w_pack_num;
          inexact_d = w_pack_inexact;
          valid_d   = 1'b1;
          state_d   = ST_DONE;
        end else begin
          mag_d = {mag_q[FIXED_W-2:0], 1'b0};
          exp_d = exp_q - 4'd1;
        end
      end
      ST_DONE: begin
        if (bus.iReady) begin
          valid_d = 1'b0;
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q   <= ST_IDLE;
      sign_q    <= 1'b0;
      mag_q     <= '0;
      exp_q     <= '0;
      valid_q   <= 1'b0;
      ready_q   <= 1'b1;
      num_q     <= F8_ZERO;
      inexact_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sign_q    <= sign_d;
      mag_q     <= mag_d;
      exp_q     <= exp_d;
      valid_q   <= valid_d;
      ready_q   <= ready_d;
      num_q     <= num_d;
      inexact_q <= inexact_d;
    end
  end

  assign bus.oValid   = valid_q;
  assign bus.oReady   = ready_q;
  assign bus.oNum     = num_q;
  assign bus.oInexact = inexact_q;

endmodule
`default_nettype wire

// File: tb/tb_float8_encoder.sv
`default_nettype none
// ============================================================================
// tb_float8_encoder : directed and random checks against an arithmetic model
// Revision: 1.0
// ============================================================================
module tb_float8_encoder;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  float8_encoder_if bus_if ();

  float8_encoder dut (
    .iClk   (clk),
    .iRst_n (rst_n),
    .bus    (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: locate the leading one of |x| and read the three bits below it.
  function automatic void ref_encode(input logic [15:0] fx, output logic [7:0] num,
                                     output logic inx, output int lat);
    int v, mag, p, scaled, mant;
    logic sgn;
    v   = int'($signed(fx));
    sgn = (v < 0);
    mag = sgn ? -v : v;
    p   = -1;
    for (int i = 0; i < 16; i++) if (mag >= (1 << i)) p = i;
    if (mag == 0) begin
      num = 8'h00; inx = 1'b0; lat = 0;
    end else if (p == 0) begin
      num = 8'h00; inx = 1'b1; lat = 16;
    end else begin
      scaled = mag * 8;
      mant   = (scaled >> p) & 7;
      inx    = ((scaled % (1 << p)) != 0);
      num    = {sgn, 4'(p), 3'(mant)};
      lat    = 16 - p;
    end
  endfunction

  task automatic encode(input logic [15:0] fx, input int hold);
    logic [7:0] e_num;
    logic       e_inx;
    int         e_lat;
    int         seen;
    ref_encode(fx, e_num, e_inx, e_lat);
    chk("ready_before_accept", 32'(bus_if.oReady), 32'd1);
    bus_if.iValid = 1'b1;
    bus_if.iFixed = fx;
    bus_if.iReady = 1'b0;
    seen = -1;
    for (int k = 0; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k == 0) begin
        bus_if.iValid = 1'b0;
        bus_if.iFixed = 16'($urandom);
      end
      if (bus_if.oValid) begin
        seen = k;
        break;
      end
    end
    chk($sformatf("latency[%04h]", fx), 32'(seen), 32'(e_lat));
    chk($sformatf("num[%04h]", fx), 32'(bus_if.oNum), 32'(e_num));
    chk($sformatf("inexact[%04h]", fx), 32'(bus_if.oInexact), 32'(e_inx));
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(bus_if.oValid), 32'd1);
      chk("hold_num", 32'(bus_if.oNum), 32'(e_num));
      chk("hold_ready_low", 32'(bus_if.oReady), 32'd0);
    end
    bus_if.iReady = 1'b1;
    @(posedge clk); #1;
    bus_if.iReady = 1'b0;
    chk("release_valid_low", 32'(bus_if.oValid), 32'd0);
    chk("release_ready_high", 32'(bus_if.oReady), 32'd1);
  endtask

  initial begin
    logic saw_valid;
    checks        = 0;
    failures      = 0;
    rst_n         = 1'b0;
    bus_if.iValid = 1'b0;
    bus_if.iFixed = 16'h0000;
    bus_if.iReady = 1'b0;

    #1;
    chk("reset_valid", 32'(bus_if.oValid), 32'd0);
    chk("reset_num", 32'(bus_if.oNum), 32'd0);
    chk("reset_inexact", 32'(bus_if.oInexact), 32'd0);
    #11 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("ready_after_reset", 32'(bus_if.oReady), 32'd1);

    // Directed reference points
    encode(16'h0100, 0);
    encode(16'hFE80, 0);
    encode(16'h8000, 0);
    encode(16'h0123, 0);
    encode(16'h0001, 0);
    encode(16'h7FFF, 1);
    encode(16'h0100, 3);

    // Zero operand with iValid held high through DONE and back to IDLE
    bus_if.iValid = 1'b1;
    bus_if.iFixed = 16'h0000;
    bus_if.iReady = 1'b0;
    @(posedge clk); #1;
    chk("zero_valid_at_accept", 32'(bus_if.oValid), 32'd1);
    chk("zero_num", 32'(bus_if.oNum), 32'd0);
    chk("zero_inexact", 32'(bus_if.oInexact), 32'd0);
    chk("zero_ready_low", 32'(bus_if.oReady), 32'd0);
    @(posedge clk); #1;
    chk("zero_no_reaccept", 32'(bus_if.oReady), 32'd0);
    chk("zero_valid_held", 32'(bus_if.oValid), 32'd1);
    bus_if.iReady = 1'b1;
    bus_if.iFixed = 16'h0100;
    @(posedge clk); #1;
    bus_if.iReady = 1'b0;
    chk("zero_release_valid", 32'(bus_if.oValid), 32'd0);
    chk("zero_release_ready", 32'(bus_if.oReady), 32'd1);
    @(posedge clk); #1;
    chk("held_valid_accept", 32'(bus_if.oReady), 32'd0);
    bus_if.iValid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    chk("held_valid_edge7", 32'(bus_if.oValid), 32'd0);
    @(posedge clk); #1;
    chk("held_valid_edge8", 32'(bus_if.oValid), 32'd1);
    chk("held_valid_num", 32'(bus_if.oNum), 32'h40);
    bus_if.iReady = 1'b1;
    @(posedge clk); #1;
    bus_if.iReady = 1'b0;

    // Reset asserted in the middle of normalisation
    bus_if.iValid = 1'b1;
    bus_if.iFixed = 16'h0001;
    @(posedge clk); #1;
    bus_if.iValid = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(bus_if.oValid), 32'd0);
    chk("midrst_num", 32'(bus_if.oNum), 32'd0);
    chk("midrst_inexact", 32'(bus_if.oInexact), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (bus_if.oValid) saw_valid = 1'b1;
    end
    chk("midrst_no_output", 32'(saw_valid), 32'd0);
    encode(16'h0100, 0);

    // Random operands with random downstream back-pressure
    for (int n = 0; n < 24; n++) begin
      encode(16'($urandom), int'($urandom_range(0, 2)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/float8_encoder.md
FLOAT8_ENCODER -- requirements
Module: float8_encoder

Interface
REQ-001 Parameters SHALL be none; widths are fixed at 16-bit Q8.8 input and 8-bit Float8 output.
REQ-002 iClk  input  1  sole clock, rising-edge.
REQ-003 iRst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 iValid  input  1  upstream offers iFixed.
REQ-005 oReady  output  1  encoder can accept; high only in IDLE.
REQ-006 iFixed  input  16  signed two's-complement Q8.8 operand (bit 0 = 2^-8).
REQ-007 oValid  output  1  oNum/oInexact valid.
REQ-008 iReady  input  1  downstream accepts result.
REQ-009 oNum  output  8  Float8 result: [7] sign, [6:3] exponent, [2:0] mantissa, hidden leading 1; value = 1.mmm x 2^(E-8); any word with [6:0]==0 is zero.
REQ-010 oInexact  output  1  nonzero magnitude bits were truncated or flushed.

Function
REQ-011 Input acceptance SHALL occur on a rising edge with iValid && oReady; iFixed is ignored otherwise.
REQ-012 On acceptance the block SHALL latch sign = iFixed[15] and mag = |iFixed| as 16-bit unsigned (0x8000 -> 0x8000), and load exponent counter = 15.
REQ-013 FSM states SHALL be IDLE, NORM and DONE.
REQ-014 IDLE -> DONE on acceptance when mag == 0, with oNum = 0x00 and oInexact = 0 (sign forced 0).
REQ-015 IDLE -> NORM on acceptance when mag != 0.
REQ-016 In NORM, each edge with mag[15] == 0 SHALL shift mag left by 1 and decrement the exponent; no other state change.
REQ-017 In NORM, an edge with mag[15] == 1 SHALL register oNum = {sign, exp, mag[14:12]} and oInexact = |mag[11:0]|, then go to DONE.
REQ-018 Mantissa rounding SHALL be truncation, matching the team's Float8 adder.
REQ-019 If the encoded word has [6:0] == 0 (leading one at bit 0), oNum SHALL be 0x00 and oInexact = 1.
REQ-020 Latency: with the leading one at bit p of mag, oValid SHALL rise after edge 16-p, counting the accept edge as 0 (p=15 -> 1, p=0 -> 16); for zero input oValid rises at the accept edge.
REQ-021 In DONE, oValid = 1; oNum and oInexact SHALL stay stable until iValid... until iReady is sampled high; that edge returns the FSM to IDLE.
REQ-022 No acceptance SHALL occur in the DONE->IDLE edge; the next input is accepted at the earliest one cycle later (throughput: one result per latency+2 cycles).
REQ-023 The exponent counter SHALL never wrap; NORM is provably exited by exp = 0 because mag != 0.

Reset
REQ-024 Asserting iRst_n low SHALL immediately force IDLE, oValid = 0, oNum = 0x00, oInexact = 0, mag = 0, exp = 0; oReady = 1 after release.
REQ-025 Reset during NORM or DONE SHALL discard the in-flight operand with no output produced.

Structure
REQ-026 Float8 field positions, EXP_MAX = 15, bias = 8 and the zero encoding SHALL live in the shared Float8 package also used by Float8Adder.
REQ-027 A combinational sub-module float8_pack SHALL form {sign, exp, mant} plus the zero/flush rule; the FSM and shifter stay in float8_encoder.

Verification
REQ-028 iFixed=0x0100 (1.0) -> oNum=0x40, oInexact=0, oValid after edge 8.
REQ-029 iFixed=0xFE80 (-1.5) -> oNum=0xC4, oInexact=0; iFixed=0x8000 -> oNum=0xF8, oValid after edge 1.
REQ-030 iFixed=0x0123 -> oNum=0x41, oInexact=1; iFixed=0x0001 -> oNum=0x00, oInexact=1, oValid after edge 16.
REQ-031 iFixed=0x0000 -> oNum=0x00, oInexact=0, oValid after accept edge; iValid held high must not re-accept until oValid drops.
REQ-032 iReady held low 3 cycles in DONE -> oNum/oValid stable, oReady=0 throughout; release -> IDLE next edge.
REQ-033 iRst_n pulsed low mid-NORM for 0x0001 -> outputs zero asynchronously, no oValid; next operand 0x0100 encodes to 0x40.
